cajero_param: RTL and testbench

Parametrised ATM session controller, the next generation of the single-PIN teller block. It accepts a card, collects an N-digit BCD PIN through a strobe interface and enforces a configurable attempt limit with warning and lock-out. After a correct PIN it runs any number of deposit and withdrawal transactions against an internal balance, with a per-session withdrawal limit. It sits between the keypad/card-reader front end and the cash dispenser.

---
 rtl/cajero_param.sv | 190 +++++++++++++++++++
 tb/tb_cajero_param.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/cajero_param.sv
// cajero_param: ATM session controller.
// Card detection, N-digit BCD PIN entry with attempt counting and lock-out,
// then deposit/withdrawal transactions against an internal balance with a
// per-session withdrawal limit. All outputs are registered.
module cajero_param #(
  parameter int                N_DIGITOS       = 4,
  parameter int                MAX_INTENTOS    = 3,
  parameter int                BAL_W           = 64,
  parameter int                MONTO_W         = 32,
  parameter longint unsigned   BALANCE_INICIAL = 150000,
  parameter longint unsigned   LIMITE_RETIRO   = 100000
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   TARJETA_RECIBIDA,
  input  logic [4*N_DIGITOS-1:0] PIN,
  input  logic [3:0]             DIGITO,
  input  logic                   DIGITO_STB,
  input  logic                   TIPO_TRANS,
  input  logic [MONTO_W-1:0]     MONTO,
  input  logic                   MONTO_STB,
  output logic                   BALANCE_ACTUALIZADO,
  output logic                   ENTREGAR_DINERO,
  output logic                   FONDOS_INSUFICIENTES,
  output logic                   PIN_INCORRECTO,
  output logic                   ADVERTENCIA,
  output logic                   BLOQUEO,
  output logic [BAL_W-1:0]       BALANCE,
  output logic                   SESION_ACTIVA
);

  localparam int PIN_W = 4 * N_DIGITOS;
  localparam int CNT_W = $clog2(N_DIGITOS + 1);
  localparam int INT_W = $clog2(MAX_INTENTOS + 1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PIN_ENTRADA = 2'd1,
    TRANSACCION = 2'd2,
    BLOQUEADO   = 2'd3
  } estado_t;

  estado_t            estado, estado_n;
  logic [CNT_W-1:0]   cuenta, cuenta_n;
  logic [PIN_W-1:0]   entrada, entrada_n, entrada_nueva;
  logic [INT_W-1:0]   intentos, intentos_n, intentos_inc;
  logic [BAL_W-1:0]   retirado, retirado_n;
  logic [BAL_W-1:0]   balance_n;
  logic [BAL_W-1:0]   monto_ext;
  logic               digito_ok;
  logic               act_n, entregar_n, fondos_n, pin_inc_n;
  logic               adv_n, bloqueo_n, sesion_n;

  // Saturating add: clamps at the all-ones balance instead of wrapping.
  function automatic logic [BAL_W-1:0] suma_sat(input logic [BAL_W-1:0] a,
                                                input logic [BAL_W-1:0] b);
    logic [BAL_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[BAL_W] ? {BAL_W{1'b1}} : s[BAL_W-1:0];
  endfunction

  // Session limit check done one bit wider so the sum can never wrap.
  function automatic logic excede_limite(input logic [BAL_W-1:0] ret,
                                         input logic [BAL_W-1:0] m);
    logic [BAL_W:0] s;
    s = {1'b0, ret} + {1'b0, m};
    return s > (BAL_W+1)'(LIMITE_RETIRO);
  endfunction

  assign monto_ext     = BAL_W'(MONTO);
  assign digito_ok     = DIGITO_STB && (DIGITO <= 4'd9);
  assign entrada_nueva = {entrada[PIN_W-5:0], DIGITO};
  assign intentos_inc  = intentos + 1'b1;

  // Next-state, datapath updates and next values of the registered outputs.
  always_comb begin
    estado_n   = estado;
    cuenta_n   = cuenta;
    entrada_n  = entrada;
    intentos_n = intentos;
    retirado_n = retirado;
    balance_n  = BALANCE;
    act_n      = 1'b0;
    entregar_n = 1'b0;
    fondos_n   = 1'b0;
    pin_inc_n  = 1'b0;

    case (estado)
      IDLE: begin
        if (TARJETA_RECIBIDA) begin
          estado_n  = PIN_ENTRADA;
          cuenta_n  = '0;
          entrada_n = '0;
        end
      end

      PIN_ENTRADA: begin
        if (!TARJETA_RECIBIDA) begin
          // Removal wins over a simultaneous last digit: no attempt counted.
          estado_n   = IDLE;
          cuenta_n   = '0;
          entrada_n  = '0;
          retirado_n = '0;
        end else if (digito_ok) begin
          entrada_n = entrada_nueva;
          if (cuenta == CNT_W'(N_DIGITOS - 1)) begin
            cuenta_n = '0;
            if (entrada_nueva == PIN) begin
              intentos_n = '0;
              estado_n   = TRANSACCION;
            end else begin
              intentos_n = intentos_inc;
              pin_inc_n  = 1'b1;
              if (intentos_inc == INT_W'(MAX_INTENTOS))
                estado_n = BLOQUEADO;
            end
          end else begin
            cuenta_n = cuenta + 1'b1;
          end
        end
      end

      TRANSACCION: begin
        if (!TARJETA_RECIBIDA) begin
          // Removal wins over a simultaneous transaction strobe.
          estado_n   = IDLE;
          cuenta_n   = '0;
          entrada_n  = '0;
          retirado_n = '0;
        end else if (MONTO_STB && (monto_ext != '0)) begin
          if (!TIPO_TRANS) begin
            balance_n = suma_sat(BALANCE, monto_ext);
            act_n     = 1'b1;
          end else if ((monto_ext > BALANCE) || excede_limite(retirado, monto_ext)) begin
            fondos_n = 1'b1;
          end else begin
            balance_n  = BALANCE - monto_ext;
            retirado_n = retirado + monto_ext;
            act_n      = 1'b1;
            entregar_n = 1'b1;
          end
        end
      end

      BLOQUEADO: begin
        estado_n = BLOQUEADO;
      end

      default: estado_n = IDLE;
    endcase

    sesion_n  = (estado_n == TRANSACCION);
    bloqueo_n = (estado_n == BLOQUEADO);
    adv_n     = (intentos_n == INT_W'(MAX_INTENTOS - 1)) && (estado_n != BLOQUEADO);
  end

  // State, counters, balance and all outputs registered on one edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      estado               <= IDLE;
      cuenta               <= '0;
      entrada              <= '0;
      intentos             <= '0;
      retirado             <= '0;
      BALANCE              <= BAL_W'(BALANCE_INICIAL);
      BALANCE_ACTUALIZADO  <= 1'b0;
      ENTREGAR_DINERO      <= 1'b0;
      FONDOS_INSUFICIENTES <= 1'b0;
      PIN_INCORRECTO       <= 1'b0;
      ADVERTENCIA          <= 1'b0;
      BLOQUEO              <= 1'b0;
      SESION_ACTIVA        <= 1'b0;
    end else begin
      estado               <= estado_n;
      cuenta               <= cuenta_n;
      entrada              <= entrada_n;
      intentos             <= intentos_n;
      retirado             <= retirado_n;
      BALANCE              <= balance_n;
      BALANCE_ACTUALIZADO  <= act_n;
      ENTREGAR_DINERO      <= entregar_n;
      FONDOS_INSUFICIENTES <= fondos_n;
      PIN_INCORRECTO       <= pin_inc_n;
      ADVERTENCIA          <= adv_n;
      BLOQUEO              <= bloqueo_n;
      SESION_ACTIVA        <= sesion_n;
    end
  end

endmodule

// File: tb/tb_cajero_param.sv
// Directed bench for cajero_param: default instance (a), a 32-bit balance
// instance for saturation (b) and a 6-digit / 2-attempt instance (c).
module tb_cajero_param;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        card_a = 1'b0, card_b = 1'b0, card_c = 1'b0;
  logic [3:0]  digito = 4'd0;
  logic        digito_stb = 1'b0;
  logic        tipo = 1'b0;
  logic [31:0] monto = 32'd0;
  logic        monto_stb = 1'b0;

  logic        act_a, ent_a, fon_a, pin_a, adv_a, blq_a, ses_a;
  logic [63:0] bal_a;
  logic        act_b, ent_b, fon_b, pin_b, adv_b, blq_b, ses_b;
  logic [31:0] bal_b;
  logic        act_c, ent_c, fon_c, pin_c, adv_c, blq_c, ses_c;
  logic [63:0] bal_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cajero_param dut_a (
    .CLK(clk), .RESET(reset), .TARJETA_RECIBIDA(card_a), .PIN(16'h6767),
    .DIGITO(digito), .DIGITO_STB(digito_stb), .TIPO_TRANS(tipo), .MONTO(monto),
    .MONTO_STB(monto_stb), .BALANCE_ACTUALIZADO(act_a), .ENTREGAR_DINERO(ent_a),
    .FONDOS_INSUFICIENTES(fon_a), .PIN_INCORRECTO(pin_a), .ADVERTENCIA(adv_a),
    .BLOQUEO(blq_a), .BALANCE(bal_a), .SESION_ACTIVA(ses_a));

  cajero_param #(.BAL_W(32)) dut_b (
    .CLK(clk), .RESET(reset), .TARJETA_RECIBIDA(card_b), .PIN(16'h6767),
    .DIGITO(digito), .DIGITO_STB(digito_stb), .TIPO_TRANS(tipo), .MONTO(monto),
    .MONTO_STB(monto_stb), .BALANCE_ACTUALIZADO(act_b), .ENTREGAR_DINERO(ent_b),
    .FONDOS_INSUFICIENTES(fon_b), .PIN_INCORRECTO(pin_b), .ADVERTENCIA(adv_b),
    .BLOQUEO(blq_b), .BALANCE(bal_b), .SESION_ACTIVA(ses_b));

  cajero_param #(.N_DIGITOS(6), .MAX_INTENTOS(2)) dut_c (
    .CLK(clk), .RESET(reset), .TARJETA_RECIBIDA(card_c), .PIN(24'h123456),
    .DIGITO(digito), .DIGITO_STB(digito_stb), .TIPO_TRANS(tipo), .MONTO(monto),
    .MONTO_STB(monto_stb), .BALANCE_ACTUALIZADO(act_c), .ENTREGAR_DINERO(ent_c),
    .FONDOS_INSUFICIENTES(fon_c), .PIN_INCORRECTO(pin_c), .ADVERTENCIA(adv_c),
    .BLOQUEO(blq_c), .BALANCE(bal_c), .SESION_ACTIVA(ses_c));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dig(input logic [3:0] d);
    digito = d;
    digito_stb = 1'b1;
    tick();
    digito_stb = 1'b0;
  endtask

  task automatic enter_pin(input logic [23:0] p, input int n);
    for (int i = n - 1; i >= 0; i--) dig(p[4*i +: 4]);
  endtask

  task automatic trans(input logic t, input logic [31:0] m);
    tipo = t;
    monto = m;
    monto_stb = 1'b1;
    tick();
    monto_stb = 1'b0;
  endtask

  task automatic do_reset();
    card_a = 1'b0; card_b = 1'b0; card_c = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #2;
    do_reset();
    tick();
    chk("rst_balance", bal_a, 64'd150000);
    chk("rst_outputs", {act_a, ent_a, fon_a, pin_a, adv_a, blq_a, ses_a}, 0);

    // Correct PIN then withdrawal of 20000
    card_a = 1'b1;
    tick();
    enter_pin(24'h6767, 4);
    chk("pin_ok_sesion", ses_a, 1);
    chk("pin_ok_no_inc", pin_a, 0);
    trans(1'b1, 32'd20000);
    chk("ret20k_entregar", ent_a, 1);
    chk("ret20k_act", act_a, 1);
    chk("ret20k_balance", bal_a, 64'd130000);
    tick();
    chk("ret20k_pulse_len", {ent_a, act_a}, 0);
    chk("ret20k_bal_hold", bal_a, 64'd130000);

    // Wrong PINs, warning, lock-out
    do_reset();
    card_a = 1'b1;
    tick();
    enter_pin(24'h1234, 4);
    chk("bad1_inc", pin_a, 1);
    chk("bad1_adv", adv_a, 0);
    tick();
    chk("bad1_inc_len", pin_a, 0);
    enter_pin(24'h6760, 4);
    chk("bad2_inc", pin_a, 1);
    chk("bad2_adv", adv_a, 1);
    enter_pin(24'h0000, 4);
    chk("bad3_bloqueo", blq_a, 1);
    chk("bad3_adv", adv_a, 0);
    chk("bad3_inc", pin_a, 1);
    card_a = 1'b0;
    tick();
    card_a = 1'b1;
    tick();
    enter_pin(24'h6767, 4);
    chk("locked_bloqueo", blq_a, 1);
    chk("locked_sesion", ses_a, 0);
    do_reset();
    chk("unlock_bloqueo", blq_a, 0);
    chk("unlock_balance", bal_a, 64'd150000);

    // Session withdrawal limit
    card_a = 1'b1;
    tick();
    enter_pin(24'h6767, 4);
    trans(1'b1, 32'd60000);
    chk("ret60k_balance", bal_a, 64'd90000);
    trans(1'b1, 32'd50000);
    chk("lim_fondos", fon_a, 1);
    chk("lim_no_entregar", {ent_a, act_a}, 0);
    chk("lim_balance", bal_a, 64'd90000);
    trans(1'b1, 32'd0);
    chk("zero_no_pulse", {ent_a, act_a, fon_a}, 0);
    card_a = 1'b0;
    tick();
    chk("out_sesion", ses_a, 0);
    card_a = 1'b1;
    tick();
    enter_pin(24'h6767, 4);
    trans(1'b1, 32'd50000);
    chk("new_sess_entregar", ent_a, 1);
    chk("new_sess_balance", bal_a, 64'd40000);
    // Back-to-back: deposit then withdrawal seeing the updated balance
    trans(1'b0, 32'd10000);
    chk("dep_act", act_a, 1);
    chk("dep_balance", bal_a, 64'd50000);
    trans(1'b1, 32'd45000);
    chk("b2b_entregar", ent_a, 1);
    chk("b2b_balance", bal_a, 64'd5000);

    // Withdrawal above balance
    do_reset();
    card_a = 1'b1;
    tick();
    enter_pin(24'h6767, 4);
    trans(1'b1, 32'd200000);
    chk("over_fondos", fon_a, 1);
    chk("over_only", {ent_a, act_a}, 0);
    chk("over_balance", bal_a, 64'd150000);

    // Invalid digits interleaved are ignored
    card_a = 1'b0;
    tick();
    card_a = 1'b1;
    tick();
    dig(4'hA); dig(4'h6); dig(4'hA); dig(4'h7); dig(4'h6); dig(4'hA);
    chk("hexA_not_yet", ses_a, 0);
    dig(4'h7);
    chk("hexA_sesion", ses_a, 1);

    // Reset mid-entry
    card_a = 1'b0;
    tick();
    card_a = 1'b1;
    tick();
    dig(4'h6); dig(4'h7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_outputs", {act_a, ent_a, fon_a, pin_a, adv_a, blq_a, ses_a}, 0);
    chk("midrst_balance", bal_a, 64'd150000);
    card_a = 1'b0;

    // Saturating deposit with a 32-bit balance
    do_reset();
    card_b = 1'b1;
    tick();
    enter_pin(24'h6767, 4);
    chk("b_sesion", ses_b, 1);
    trans(1'b0, 32'hFFFFFFFF);
    chk("b_sat_balance", bal_b, 64'hFFFFFFFF);
    chk("b_sat_act", act_b, 1);
    card_b = 1'b0;
    tick();

    // Six-digit PIN, two attempts
    do_reset();
    card_c = 1'b1;
    tick();
    enter_pin(24'h123456, 6);
    chk("c_sesion", ses_c, 1);
    card_c = 1'b0;
    tick();
    card_c = 1'b1;
    tick();
    enter_pin(24'h123457, 6);
    chk("c_bad1_inc", pin_c, 1);
    chk("c_bad1_adv", adv_c, 1);
    chk("c_bad1_blq", blq_c, 0);
    enter_pin(24'h654321, 6);
    chk("c_bad2_blq", blq_c, 1);
    chk("c_bad2_adv", adv_c, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
